// File: rtl/multi_chan_acq_controller.sv
// Multi-channel acquisition controller: delays accepted triggers, fans them
// out to NUM_CHAN channels, collects done flags under a timeout and writes
// one {timeout_mask, chan_mask, trig_type, trig_num} record per trigger.
module multi_chan_acq_controller #(
    parameter int unsigned NUM_CHAN       = 5,
    parameter int unsigned TRIG_NUM_WIDTH = 24,
    parameter int unsigned DELAY_WIDTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 40000
) (
    input  logic                                   ttc_clk,
    input  logic                                   reset40_n,
    input  logic [NUM_CHAN-1:0]                    chan_en,
    input  logic [DELAY_WIDTH-1:0]                 trig_delay,
    input  logic                                   trigger,
    input  logic [1:0]                             trig_type,
    input  logic [TRIG_NUM_WIDTH-1:0]              trig_num,
    output logic                                   acq_ready,
    input  logic [NUM_CHAN-1:0]                    acq_dones,
    output logic [NUM_CHAN-1:0]                    acq_enable,
    output logic [NUM_CHAN-1:0]                    acq_trig,
    input  logic                                   fifo_ready,
    output logic                                   fifo_valid,
    output logic [2*NUM_CHAN+2+TRIG_NUM_WIDTH-1:0] fifo_data,
    output logic [2:0]                             state,
    output logic [15:0]                            dropped_count,
    output logic [15:0]                            timeout_count
);

    localparam int unsigned REC_W = 2*NUM_CHAN + 2 + TRIG_NUM_WIDTH;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_TRIG  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4
    } state_t;

    state_t                    st, st_nx;
    logic [NUM_CHAN-1:0]       mask_q, mask_nx;
    logic [1:0]                type_q, type_nx;
    logic [TRIG_NUM_WIDTH-1:0] num_q, num_nx;
    logic [DELAY_WIDTH-1:0]    dcnt_q, dcnt_nx;
    logic [TMO_W-1:0]          tcnt_q, tcnt_nx;
    logic [NUM_CHAN-1:0]       seen_q, seen_nx;

    logic                      acq_ready_nx;
    logic [NUM_CHAN-1:0]       acq_enable_nx;
    logic [NUM_CHAN-1:0]       acq_trig_nx;
    logic                      fifo_valid_nx;
    logic [REC_W-1:0]          fifo_data_nx;
    logic [15:0]               dropped_nx;
    logic [15:0]               timeout_nx;

    assign state = 3'(st);

    // State, event context and registered outputs
    always_ff @(posedge ttc_clk) begin
        if (!reset40_n) begin
            st            <= ST_IDLE;
            mask_q        <= '0;
            type_q        <= '0;
            num_q         <= '0;
            dcnt_q        <= '0;
            tcnt_q        <= '0;
            seen_q        <= '0;
            acq_ready     <= 1'b0;
            acq_enable    <= '0;
            acq_trig      <= '0;
            fifo_valid    <= 1'b0;
            fifo_data     <= '0;
            dropped_count <= '0;
            timeout_count <= '0;
        end else begin
            st            <= st_nx;
            mask_q        <= mask_nx;
            type_q        <= type_nx;
            num_q         <= num_nx;
            dcnt_q        <= dcnt_nx;
            tcnt_q        <= tcnt_nx;
            seen_q        <= seen_nx;
            acq_ready     <= acq_ready_nx;
            acq_enable    <= acq_enable_nx;
            acq_trig      <= acq_trig_nx;
            fifo_valid    <= fifo_valid_nx;
            fifo_data     <= fifo_data_nx;
            dropped_count <= dropped_nx;
            timeout_count <= timeout_nx;
        end
    end

    // Next state, event context and output values derived from the next state
    always_comb begin
        st_nx        = st;
        mask_nx      = mask_q;
        type_nx      = type_q;
        num_nx       = num_q;
        dcnt_nx      = dcnt_q;
        tcnt_nx      = tcnt_q;
        seen_nx      = seen_q;
        fifo_data_nx = fifo_data;
        dropped_nx   = dropped_count;
        timeout_nx   = timeout_count;

        // A trigger while not ready is lost; count it
        if (trigger && !acq_ready && (dropped_count != 16'hFFFF)) begin
            dropped_nx = dropped_count + 16'd1;
        end

        case (st)
            ST_IDLE: begin
                if (trigger && acq_ready) begin
                    mask_nx = chan_en;
                    type_nx = trig_type;
                    num_nx  = trig_num;
                    dcnt_nx = trig_delay;
                    if (chan_en == '0) begin
                        st_nx        = ST_STORE;
                        fifo_data_nx = {{NUM_CHAN{1'b0}}, chan_en, trig_type, trig_num};
                    end else if (trig_delay == '0) begin
                        st_nx = ST_TRIG;
                    end else begin
                        st_nx = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                dcnt_nx = dcnt_q - DELAY_WIDTH'(1);
                if (dcnt_q == DELAY_WIDTH'(1)) begin
                    st_nx = ST_TRIG;
                end
            end
            ST_TRIG: begin
                seen_nx = '0;
                tcnt_nx = '0;
                st_nx   = ST_WAIT;
            end
            ST_WAIT: begin
                seen_nx = seen_q | (acq_dones & mask_q);
                tcnt_nx = tcnt_q + TMO_W'(1);
                // All dones win over a coincident timeout
                if (seen_nx == mask_q) begin
                    st_nx        = ST_STORE;
                    fifo_data_nx = {{NUM_CHAN{1'b0}}, mask_q, type_q, num_q};
                end else if (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    st_nx        = ST_STORE;
                    fifo_data_nx = {mask_q & ~seen_nx, mask_q, type_q, num_q};
                    if (timeout_count != 16'hFFFF) begin
                        timeout_nx = timeout_count + 16'd1;
                    end
                end
            end
            ST_STORE: begin
                if (fifo_valid && fifo_ready) begin
                    st_nx = ST_IDLE;
                end
            end
            default: begin
                st_nx = ST_IDLE;
            end
        endcase

        acq_ready_nx  = (st_nx == ST_IDLE);
        fifo_valid_nx = (st_nx == ST_STORE);
        acq_trig_nx   = (st_nx == ST_TRIG) ? mask_nx : '0;
        case (st_nx)
            ST_IDLE:           acq_enable_nx = chan_en;
            ST_DELAY, ST_TRIG: acq_enable_nx = mask_nx;
            ST_WAIT:           acq_enable_nx = mask_nx & ~seen_nx;
            default:           acq_enable_nx = '0;
        endcase
    end

endmodule

// File: doc/multi_chan_acq_controller.md
# multi_chan_acq_controller

Parametrised channel acquisition controller for the 40 MHz TTC domain. It accepts triggers from the TTC trigger receiver, delays them, fans them out to `NUM_CHAN` channel FPGAs, and collects per-channel done flags under a timeout. It writes one acquisition record per trigger into the Acquisition Event FIFO. Compared with the fixed five-channel controller, it adds a channel-count parameter, a done timeout with a per-channel timeout mask, empty-mask events, and saturating counters for dropped triggers and timeouts.

## Interface

Parameters:
- `NUM_CHAN`, 5: number of channel FPGAs.
- `TRIG_NUM_WIDTH`, 24: trigger number width.
- `DELAY_WIDTH`, 4: trigger delay width.
- `TIMEOUT_CYCLES`, 40000: maximum WAIT duration in clocks (1 ms at 40 MHz). Must be ≥ 2.

Ports:
- `ttc_clk` in, 1: 40 MHz clock. Single clock domain.
- `reset40_n` in, 1: synchronous reset, active-low.
- `chan_en` in, NUM_CHAN: enabled channels. Sampled at trigger acceptance.
- `trig_delay` in, DELAY_WIDTH: clocks between trigger acceptance and `acq_trig`.
- `trigger` in, 1: trigger strobe.
- `trig_type` in, 2: trigger type.
- `trig_num` in, TRIG_NUM_WIDTH: trigger number.
- `acq_ready` out, 1: ready to accept a trigger.
- `acq_dones` in, NUM_CHAN: channel done levels.
- `acq_enable` out, NUM_CHAN: per-channel arm.
- `acq_trig` out, NUM_CHAN: per-channel trigger pulse.
- `fifo_ready` in, 1: FIFO write handshake, ready.
- `fifo_valid` out, 1: FIFO write handshake, valid.
- `fifo_data` out, 2*NUM_CHAN+2+TRIG_NUM_WIDTH: the record {timeout_mask, chan_mask, trig_type, trig_num}, MSB first.
- `state` out, 3: FSM state.
- `dropped_count` out, 16: triggers ignored while busy. Saturates at 0xFFFF.
- `timeout_count` out, 16: records closed by timeout. Saturates at 0xFFFF.

## Operation

- FSM states: IDLE=0, DELAY=1, TRIG=2, WAIT=3, STORE=4. Encodings 5–7 are illegal and go to IDLE on the next edge.
- All outputs are registered.
- Reset (`reset40_n`=0 at an edge) sets state IDLE and every output to 0, including both counters and `fifo_data`. Reset mid-operation aborts the event; no record is written.
- **IDLE**
  - `acq_ready`=1. `acq_enable`=`chan_en`.
  - Acceptance = `trigger` && `acq_ready`. On acceptance, latch `trig_num`, `trig_type`, chan_mask=`chan_en`, and load the delay counter with `trig_delay`.
  - Next state:
    - chan_mask==0 → STORE with timeout_mask=0 (empty event).
    - else `trig_delay`==0 → TRIG.
    - else → DELAY.
- **DELAY**: decrement the counter each clock. Leave for TRIG when the counter reaches 1, so DELAY lasts exactly `trig_delay` clocks. `acq_enable`=chan_mask.
- **TRIG**: exactly one clock. `acq_trig`=chan_mask (0 in every other state). Clear done_seen and the timeout counter. Next state is WAIT.
- **WAIT**
  - Each clock: done_seen |= `acq_dones` & chan_mask.
  - `acq_enable` = chan_mask & ~done_seen.
  - The timeout counter increments each clock.
  - Exit when (done_seen | `acq_dones`) & chan_mask == chan_mask → STORE with timeout_mask=0.
  - Otherwise, when the counter == TIMEOUT_CYCLES−1 → STORE with timeout_mask = chan_mask & ~(done_seen | `acq_dones`), and `timeout_count` +1 (saturating).
  - If the last done and the timeout occur on the same clock, the done wins: no timeout is recorded.
- **STORE**
  - `fifo_valid`=1 with `fifo_data` stable. `acq_enable`=0.
  - Holds indefinitely while `fifo_ready`=0.
  - When `fifo_valid`&&`fifo_ready`: go to IDLE, and `acq_ready` returns to 1 on the same edge.
- A `trigger` high at any edge where `acq_ready`=0 (including the first clock after reset) is ignored and increments `dropped_count` (saturating).
- `acq_dones` are ignored outside WAIT.

## Timing

- Reset release: `acq_ready` rises 1 clock after the first edge with `reset40_n`=1.
- Trigger sampled at edge k:
  - `acq_ready`=0 from k.
  - `acq_trig` is high during the cycle after edge k+`trig_delay`, for exactly 1 clock.
- Done to record: if all dones are present at edge m in WAIT, `fifo_valid`=1 from edge m.
- Timeout: `fifo_valid` rises exactly TIMEOUT_CYCLES clocks after `acq_trig` falls.
- Empty mask: `fifo_valid`=1 from edge k. No `acq_trig`.
- Throughput: minimum trigger-to-trigger spacing is `trig_delay`+4 clocks when `fifo_ready` stays 1 and the dones are already high.

## Test plan

- **Delay 3, all dones**: reset, then `chan_en`=5'b10101, `trig_delay`=3, `trigger` with num=0x000001, type=1. Expect `acq_trig`=5'b10101 for 1 clock, 4 cycles after the trigger edge. Raise dones → record {0, 10101, 01, 000001}. `acq_ready` returns to 1.
- **Timeout**: `TIMEOUT_CYCLES`=16, chan 1 never done, others done. Expect `fifo_valid` 16 clocks after `acq_trig`, timeout_mask=5'b00010, `timeout_count`=1. `acq_enable`=5'b00010 during late WAIT.
- **Done/timeout tie**: the last done arrives on the timeout clock → timeout_mask=0, `timeout_count` unchanged.
- **Backpressure and drops**: `fifo_ready`=0 for 20 clocks while 3 triggers arrive → record held stable, `dropped_count`=3. After `fifo_ready`=1, one record is written.
- **Empty mask**: `chan_en`=0, trigger num=7 → no `acq_trig`, record {0, 0, type, 7} at the next edge.
- **Reset mid-WAIT**: `reset40_n` low 1 clock → all outputs 0, no `fifo_valid`. The next trigger proceeds normally.
